// File: rtl/score_pkg.sv
// Shared encodings for the score bookkeeping stage.
package score_pkg;
  localparam logic [1:0] GRADE_MISS    = 2'd0;
  localparam logic [1:0] GRADE_GOOD    = 2'd1;
  localparam logic [1:0] GRADE_PERFECT = 2'd2;
  localparam logic [1:0] GRADE_RSVD    = 2'd3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ADD  = 1'b1;

  localparam int BCD_MAX = 9;
endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder: a + b + ci, decimal-corrected, with carry out.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] raw;
  logic [4:0] adj;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    adj = raw + 5'd6;
    co  = raw > 5'd9;
    s   = co ? adj[3:0] : raw[3:0];
  end
endmodule

// File: rtl/score_accum.sv
// Hit-event score accumulator: combo tracking, digit-serial BCD add,
// saturation at all nines and a frame-stable display latch.
module score_accum
  import score_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int GOOD_PTS    = 2,
  parameter int PERFECT_PTS = 5,
  parameter int COMBO_X2    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hit_valid,
  output logic              hit_ready,
  input  logic [1:0]        hit_grade,
  input  logic              frame_start,
  input  logic              clear,
  output logic [4*NDIG-1:0] disp_digits,
  output logic [7:0]        combo,
  output logic              sat
);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  logic [NDIG-1:0][3:0] work;
  logic [NDIG-1:0][3:0] disp;
  logic [0:0]           state;
  logic [IW-1:0]        idx;
  logic                 carry;
  logic                 pass2;
  logic                 pend;
  logic [3:0]           pts;
  logic [7:0]           combo_r;
  logic                 sat_r;

  logic       accept;
  logic       scoring;
  logic [7:0] combo_nxt;
  logic [3:0] add_b;
  logic [3:0] sum;
  logic       cout;

  assign hit_ready = (state == IDLE) && !clear;
  assign accept    = hit_valid && hit_ready;
  assign scoring   = (hit_grade == GRADE_GOOD) || (hit_grade == GRADE_PERFECT);
  assign combo_nxt = (combo_r == 8'hFF) ? combo_r : combo_r + 8'd1;
  // Points enter only at the least significant digit; higher digits just ripple carry.
  assign add_b     = (idx == '0) ? pts : 4'd0;

  bcd_digit_add u_add (
    .a  (work[idx]),
    .b  (add_b),
    .ci (carry),
    .s  (sum),
    .co (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work    <= '0;
      disp    <= '0;
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      pass2   <= 1'b0;
      pend    <= 1'b0;
      pts     <= 4'd0;
      combo_r <= 8'd0;
      sat_r   <= 1'b0;
    end else if (clear) begin
      work    <= '0;
      disp    <= '0;
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      pass2   <= 1'b0;
      pend    <= 1'b0;
      combo_r <= 8'd0;
      sat_r   <= 1'b0;
    end else if (state == IDLE) begin
      // Work is untouched on the accept edge, so a coincident frame shows the pre-hit score.
      if (frame_start || pend) begin
        disp <= work;
        pend <= 1'b0;
      end
      if (accept) begin
        if (hit_grade == GRADE_MISS) begin
          combo_r <= 8'd0;
        end else if (scoring) begin
          combo_r <= combo_nxt;
          if (!sat_r) begin
            state <= ADD;
            idx   <= '0;
            carry <= 1'b0;
            pts   <= (hit_grade == GRADE_PERFECT) ? 4'(PERFECT_PTS) : 4'(GOOD_PTS);
            pass2 <= {24'd0, combo_nxt} >= 32'(COMBO_X2);
          end
        end
      end
    end else begin
      if (frame_start)
        pend <= 1'b1;
      work[idx] <= sum;
      carry     <= cout;
      if (idx == LAST) begin
        idx   <= '0;
        carry <= 1'b0;
        if (cout) begin
          // Overflow past the top digit pins the score at all nines and ends every pass.
          work  <= {NDIG{4'(BCD_MAX)}};
          sat_r <= 1'b1;
          state <= IDLE;
        end else if (pass2) begin
          pass2 <= 1'b0;
        end else begin
          state <= IDLE;
        end
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign disp_digits = disp;
  assign combo       = combo_r;
  assign sat         = sat_r;
endmodule

// File: tb/tb_score_accum.sv
// Scoreboard bench for score_accum: a decimal score model predicts display,
// combo, saturation and busy duration for each hit.
module tb_score_accum;
  import score_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hit_valid = 1'b0;
  logic [1:0]  hit_grade = 2'd0;
  logic        frame_start = 1'b0;
  logic        clear = 1'b0;
  logic        hit_ready;
  logic [15:0] disp_digits;
  logic [7:0]  combo;
  logic        sat;

  score_accum #(.NDIG(4), .GOOD_PTS(2), .PERFECT_PTS(5), .COMBO_X2(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .hit_valid   (hit_valid),
    .hit_ready   (hit_ready),
    .hit_grade   (hit_grade),
    .frame_start (frame_start),
    .clear       (clear),
    .disp_digits (disp_digits),
    .combo       (combo),
    .sat         (sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] disp;
    logic [7:0]  combo;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  int          m_score = 0;
  int          m_combo = 0;
  logic        m_sat = 1'b0;
  logic [15:0] m_disp = 16'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_zero();
    m_score = 0; m_combo = 0; m_sat = 1'b0; m_disp = 16'h0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.disp = to_bcd(m_score); e.combo = 8'(m_combo); e.sat = m_sat;
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("disp", disp_digits, e.disp);
      chk("combo", combo, e.combo);
      chk("sat", sat, e.sat);
      m_disp = e.disp;
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!hit_ready && n < 50) begin @(negedge clk); n++; end
    if (!hit_ready) chk("ready_wait", 0, 1);
  endtask

  // Offers one hit; fmid>0 pulses frame_start that many cycles into the ADD.
  task automatic hit(input logic [1:0] g, input int fmid);
    int n, p, pass, busy, s;
    wait_ready();
    hit_valid = 1'b1; hit_grade = g;
    busy = 0;
    if (g == GRADE_MISS) m_combo = 0;
    else if (g != GRADE_RSVD) begin
      if (m_combo < 255) m_combo++;
      if (!m_sat) begin
        p = (g == GRADE_PERFECT) ? 5 : 2;
        pass = (m_combo >= 10) ? 2 : 1;
        for (int i = 0; i < pass && !m_sat; i++) begin
          busy += 4;
          s = m_score + p;
          if (s > 9999) begin m_sat = 1'b1; m_score = 9999; end
          else m_score = s;
        end
      end
    end
    @(negedge clk);
    hit_valid = 1'b0;
    n = 0;
    while (!hit_ready && n < 40) begin
      n++;
      if (fmid > 0) chk("disp_hold", disp_digits, m_disp);
      if (n == fmid) begin frame_start = 1'b1; push_exp(); end
      @(negedge clk);
      frame_start = 1'b0;
    end
    chk("busy", n, busy);
    if (fmid > 0) begin
      @(negedge clk);
      pop_chk();
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    push_exp();
    @(negedge clk);
    frame_start = 1'b0;
    pop_chk();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_zero();
  endtask

  // Reaches an exact score using the grade that does not strand an unreachable remainder.
  task automatic approach(input int target);
    int rem, nc, mult;
    while (m_score < target) begin
      rem = target - m_score;
      nc = (m_combo < 255) ? m_combo + 1 : 255;
      mult = (nc >= 10) ? 2 : 1;
      if (5*mult <= rem && rem - 5*mult != 1 && rem - 5*mult != 3) hit(GRADE_PERFECT, 0);
      else if (2*mult <= rem && rem - 2*mult != 1 && rem - 2*mult != 3) hit(GRADE_GOOD, 0);
      else if (m_combo != 0) hit(GRADE_MISS, 0);
      else break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_disp", disp_digits, 16'h0);
    chk("rst_combo", combo, 0);
    chk("rst_sat", sat, 0);
    chk("rst_ready", hit_ready, 1);

    // first perfect hit
    hit(GRADE_PERFECT, 0);
    frame();

    // combo doubling
    do_clear();
    for (int i = 0; i < 9; i++) hit(GRADE_PERFECT, 0);
    frame();
    hit(GRADE_PERFECT, 0);
    frame();
    hit(GRADE_MISS, 0);
    hit(GRADE_RSVD, 0);
    frame();
    hit(GRADE_PERFECT, 0);
    frame();

    // clear during ADD, with a hit offered in the clear cycle
    wait_ready();
    hit_valid = 1'b1; hit_grade = GRADE_PERFECT;
    @(negedge clk);
    clear = 1'b1;
    #1 chk("clr_ready", hit_ready, 0);
    @(negedge clk);
    clear = 1'b0; hit_valid = 1'b0;
    model_zero();
    #1;
    chk("clr_ready_after", hit_ready, 1);
    chk("clr_disp", disp_digits, 16'h0);
    chk("clr_combo", combo, 0);
    chk("clr_sat", sat, 0);
    @(negedge clk);
    frame();

    // ripple carry 0999 + good, with a mid-ADD frame
    approach(999);
    frame();
    hit(GRADE_MISS, 0);
    hit(GRADE_GOOD, 2);

    // saturation
    approach(9998);
    frame();
    hit(GRADE_MISS, 0);
    hit(GRADE_PERFECT, 0);
    frame();
    hit(GRADE_GOOD, 0);
    frame();

    // async reset between edges during ADD
    do_clear();
    hit(GRADE_PERFECT, 0);
    frame();
    wait_ready();
    hit_valid = 1'b1; hit_grade = GRADE_PERFECT;
    @(negedge clk);
    hit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_disp", disp_digits, 16'h0);
    chk("arst_combo", combo, 0);
    chk("arst_sat", sat, 0);
    chk("arst_ready", hit_ready, 1);
    rst = 1'b0;
    model_zero();
    @(negedge clk);
    chk("arst_ready_rel", hit_ready, 1);
    frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_accum.md
Name: score_accum

Overview:
- Score bookkeeping stage that sits directly upstream of the per-digit score renderers.
- Accepts graded hit events from the hit judge and keeps a combo count.
- Accumulates points into an NDIG-digit BCD score using a digit-serial adder.
- Publishes a frame-stable BCD digit bus. Digit i of that bus feeds the renderer instance with position index i.

Parameters:
- NDIG, 4, number of BCD score digits; digit 0 is least significant.
- GOOD_PTS, 2, points for a good hit; legal range 1..9.
- PERFECT_PTS, 5, points for a perfect hit; legal range 1..9.
- COMBO_X2, 10, combo value (after increment) at or above which a hit scores double.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- hit_valid  in  1  hit event offered
- hit_ready  out  1  block can accept a hit event
- hit_grade  in  2  0=miss, 1=good, 2=perfect, 3=reserved
- frame_start  in  1  one-cycle pulse at start of vertical blank
- clear  in  1  synchronous score/combo clear (new song)
- disp_digits  out  4*NDIG  displayed score; digit i occupies bits [4i+3:4i]
- combo  out  8  current consecutive-hit count
- sat  out  1  sticky flag: score saturated at all nines

Behaviour:
- Reset (asynchronous, active-high):
  - working score, disp_digits, combo, sat all 0
  - state IDLE, hit_ready 1
  - frame-pending flag 0
- Handshake:
  - hit_ready = (state == IDLE) and not clear.
  - A hit is accepted on a clk edge where hit_valid and hit_ready are both 1.
  - Upstream holds hit_valid and hit_grade until accepted.
- On acceptance:
  - Miss (grade 0): combo becomes 0, no add, stay IDLE.
  - Reserved (grade 3): no change at all.
  - Good or perfect:
    - combo increments, saturating at 255.
    - P = GOOD_PTS or PERFECT_PTS.
    - passes = 2 if the new combo is at least COMBO_X2, otherwise 1.
    - Go to ADD with idx=0 and carry=0.
- ADD state:
  - Each edge processes digit idx: digit[idx] = BCD sum of digit[idx], addend and carry. The addend is P when idx==0, otherwise 0. Carry is updated from that sum.
  - When idx==NDIG-1 and another pass remains: idx=0, carry=0, stay in ADD.
  - Otherwise go to IDLE.
  - A pass always takes exactly NDIG cycles; there is no early exit.
  - Acceptance at edge k: hit_ready low for NDIG (single pass) or 2*NDIG (doubled) cycles, high again after edge k+NDIG or k+2*NDIG.
- Saturation:
  - A carry out of digit NDIG-1 forces every working digit to 9 on that same edge, sets sat, and ends all passes (go to IDLE).
  - While sat=1, good/perfect hits update combo only; no ADD is entered.
- Display latch:
  - On frame_start in IDLE, disp_digits loads the working score on the next edge.
  - On frame_start while in ADD, set frame-pending. disp_digits loads on the first IDLE cycle, then frame-pending clears.
  - disp_digits never shows a partially rippled value.
- clear (highest priority after rst):
  - working score, disp_digits, combo, sat and frame-pending all go to 0.
  - Any ADD in progress is aborted to IDLE.
  - A hit offered in the same cycle is not accepted, because hit_ready is 0.
- Simultaneous events:
  - frame_start and acceptance on the same IDLE edge: disp_digits loads the pre-hit score.
  - frame_start and the final ADD edge: set pending, load on the next edge (the first IDLE cycle).
- Width rule: every working and displayed digit is always in 0..9. Per-digit sum ≤ 9+9+1 = 19; values above 9 are corrected by +6 with carry out.

Decomposition:
- Package score_pkg:
  - grade encodings GRADE_MISS, GRADE_GOOD, GRADE_PERFECT, GRADE_RSVD
  - state enum {IDLE, ADD}
  - BCD_MAX = 9
- One sub-module, bcd_digit_add: combinational; 4-bit a, 4-bit b, carry in → 4-bit digit, carry out. Instantiated once and muxed by idx.

Test Plan:
- Reset then perfect hit, combo 0→1: hit_ready low exactly 4 cycles. After the next frame_start, disp_digits=16'h0005, combo=1.
- Ripple carry: working score 0999 plus good hit → 1001; each digit updates on successive edges. A frame_start issued mid-ADD yields disp_digits=16'h1001, never an intermediate value.
- Combo doubling: 9 perfect hits from 0 reach score 0045. The 10th hit holds hit_ready low 8 cycles and gives 0055, combo=10. A miss then sets combo=0 and the next perfect adds 5 → 0060.
- Saturation: score 9998 plus perfect → digits 9999, sat=1. A further good hit leaves the score unchanged and increments combo.
- clear asserted during ADD: the next edge gives state IDLE, score 0000, disp_digits 0, combo 0, sat 0. A hit offered in that cycle is not accepted.
- Async rst pulse between clk edges, mid-ADD: outputs go to 0 immediately without an edge, and hit_ready=1 after release.
